// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and helpers for the elevator status LCD driver.
package lcd_pkg;

    localparam logic [1:0] MOVE_STOP = 2'd0;
    localparam logic [1:0] MOVE_UP   = 2'd1;
    localparam logic [1:0] MOVE_DOWN = 2'd2;
    localparam logic [1:0] MOVE_RSVD = 2'd3;

    localparam logic [7:0] FUNC_SET    = 8'h38;
    localparam logic [7:0] DISP_ON     = 8'h0C;
    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] ENTRY       = 8'h06;
    localparam logic [7:0] LINE1       = 8'h80;
    localparam logic [7:0] LINE2       = 8'hC0;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DELAY, S_NEXT} lcdState_t;

    function automatic logic [7:0] initCmd(input logic [1:0] step);
        case (step)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return CLEAR;
            default: return ENTRY;
        endcase
    endfunction

    // Double-dabble: three BCD digits {hundreds, tens, units} of a value up to 511.
    function automatic logic [11:0] toBcd(input logic [8:0] bin);
        logic [11:0] bcd;
        bcd = '0;
        for (int i = 8; i >= 0; i--) begin
            for (int d = 0; d < 3; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[10:0], bin[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/lcd_status_rom.sv
// Character generator for one frame column; the direction glyph in the last
// line-1 column exists only when LCD_ARROW_EN is defined.
module lcd_status_rom
    import lcd_pkg::*;
#(
    parameter int LINE_LEN = 16
) (
    input  logic [1:0]  snapMove,
    input  logic [11:0] bcd,
    input  logic        line2,
    input  logic [5:0]  col,
    output logic [7:0]  charOut
);

    localparam logic [39:0] ANDAR = "Andar";

    logic [63:0] motionText;
    logic [5:0]  motionLen;
    logic [2:0]  l1Sel;
    logic [2:0]  l2Sel;

    assign l1Sel = 3'd7 - col[2:0];
    assign l2Sel = 3'd4 - col[2:0];

    always_comb begin
        case (snapMove)
            MOVE_STOP: begin motionText = "Parado  "; motionLen = 6'd6; end
            MOVE_UP:   begin motionText = "Subindo "; motionLen = 6'd7; end
            MOVE_DOWN: begin motionText = "Descendo"; motionLen = 6'd8; end
            default:   begin motionText = "Erro    "; motionLen = 6'd4; end
        endcase
    end

    always_comb begin
        charOut = ASCII_SPACE;
        if (!line2) begin
            if (col < motionLen && col < 6'(LINE_LEN)) charOut = motionText[{l1Sel, 3'b000} +: 8];
`ifdef LCD_ARROW_EN
            if (col == 6'(LINE_LEN - 1)) begin
                case (snapMove)
                    MOVE_UP:   charOut = 8'h5E;
                    MOVE_DOWN: charOut = 8'h76;
                    MOVE_STOP: charOut = 8'h2D;
                    default:   charOut = 8'h3F;
                endcase
            end
`endif
        end else begin
            // Floor digits are right-justified with leading zeros blanked.
            if (col < 6'd5)       charOut = ANDAR[{l2Sel, 3'b000} +: 8];
            else if (col == 6'd6) charOut = (bcd[11:8] == 4'd0) ? ASCII_SPACE : ASCII_ZERO + {4'h0, bcd[11:8]};
            else if (col == 6'd7) charOut = (bcd[11:4] == 8'd0) ? ASCII_SPACE : ASCII_ZERO + {4'h0, bcd[7:4]};
            else if (col == 6'd8) charOut = ASCII_ZERO + {4'h0, bcd[3:0]};
        end
    end

endmodule

// File: rtl/lcd_status_display.sv
// HD44780 status-panel driver: init once, then render motion/floor frames on change.
// Build option: LCD_ARROW_EN adds a direction glyph at the end of line 1.
module lcd_status_display
    import lcd_pkg::*;
#(
    parameter int DLY_CYCLES = 262142,
    parameter int LINE_LEN   = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [1:0]         iMOVE,
    input  logic [FLOOR_W-1:0] iFLOOR,
    output logic [7:0]         oLCD_DATA,
    output logic               oLCD_RS,
    output logic               oLCD_START,
    input  logic               iLCD_DONE,
    output logic               oBUSY
);

    localparam int IW = $clog2(2*LINE_LEN + 2);
    localparam int CW = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;
    localparam logic [CW-1:0] DLY_LAST       = CW'(DLY_CYCLES - 1);
    localparam logic [IW-1:0] IDX_INIT_LAST  = IW'(3);
    localparam logic [IW-1:0] IDX_LINE2      = IW'(LINE_LEN + 1);
    localparam logic [IW-1:0] IDX_FRAME_LAST = IW'(2*LINE_LEN + 1);

    lcdState_t          state, nextState;
    logic [IW-1:0]      byteIdx, nIdx;
    logic               initPend, nInit;
    logic [CW-1:0]      dlyCnt;
    logic [1:0]         snapMove;
    logic [FLOOR_W-1:0] snapFloor;
    logic               loadByte, takeSnap, isLast, inputsChanged;
    logic [11:0]        bcd;
    logic               romLine2;
    logic [5:0]         romCol;
    logic [7:0]         romChar, byteVal;
    logic               rsVal;

    assign isLast        = initPend ? (byteIdx == IDX_INIT_LAST) : (byteIdx == IDX_FRAME_LAST);
    assign inputsChanged = (iMOVE != snapMove) || (iFLOOR != snapFloor);
    assign bcd           = toBcd(9'(snapFloor));

    // Handshake: oLCD_START rises with data/RS valid and holds them until iLCD_DONE
    // is seen in WAIT; iLCD_DONE is a don't-care in every other state.
    always_comb begin
        nextState = state;
        nIdx      = byteIdx;
        nInit     = initPend;
        loadByte  = 1'b0;
        takeSnap  = 1'b0;
        case (state)
            S_IDLE: begin
                nIdx = '0;
                if (initPend) begin
                    nextState = S_LOAD;
                    loadByte  = 1'b1;
                end else if (inputsChanged) begin
                    nextState = S_LOAD;
                    loadByte  = 1'b1;
                    takeSnap  = 1'b1;
                end
            end
            S_LOAD:  nextState = S_WAIT;
            S_WAIT:  if (iLCD_DONE) nextState = S_DELAY;
            S_DELAY: if (dlyCnt == DLY_LAST) nextState = S_NEXT;
            S_NEXT: begin
                if (!isLast) begin
                    nIdx      = byteIdx + IW'(1);
                    nextState = S_LOAD;
                    loadByte  = 1'b1;
                end else begin
                    nIdx = '0;
                    // End of init always starts a frame; end of frame only if inputs moved.
                    if (initPend || inputsChanged) begin
                        nInit     = 1'b0;
                        nextState = S_LOAD;
                        loadByte  = 1'b1;
                        takeSnap  = 1'b1;
                    end else begin
                        nextState = S_IDLE;
                    end
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_comb begin
        romLine2 = 1'b0;
        romCol   = 6'(nIdx - IW'(1));
        if (nIdx > IDX_LINE2) begin
            romLine2 = 1'b1;
            romCol   = 6'(nIdx - IDX_LINE2 - IW'(1));
        end
    end

    always_comb begin
        byteVal = ASCII_SPACE;
        rsVal   = 1'b0;
        if (nInit)                  byteVal = initCmd(nIdx[1:0]);
        else if (nIdx == '0)        byteVal = LINE1;
        else if (nIdx == IDX_LINE2) byteVal = LINE2;
        else begin
            byteVal = romChar;
            rsVal   = 1'b1;
        end
    end

    lcd_status_rom #(.LINE_LEN(LINE_LEN)) uRom (
        .snapMove (snapMove),
        .bcd      (bcd),
        .line2    (romLine2),
        .col      (romCol),
        .charOut  (romChar)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            byteIdx    <= '0;
            initPend   <= 1'b1;
            dlyCnt     <= '0;
            snapMove   <= '0;
            snapFloor  <= '0;
            oLCD_DATA  <= '0;
            oLCD_RS    <= 1'b0;
            oLCD_START <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            state    <= nextState;
            byteIdx  <= nIdx;
            initPend <= nInit;
            oBUSY    <= (nextState != S_IDLE);
            dlyCnt   <= (state == S_DELAY) ? dlyCnt + CW'(1) : '0;
            if (takeSnap) begin
                snapMove  <= iMOVE;
                snapFloor <= iFLOOR;
            end
            if (loadByte) begin
                oLCD_DATA  <= byteVal;
                oLCD_RS    <= rsVal;
                oLCD_START <= 1'b1;
            end else if (state == S_WAIT && iLCD_DONE) begin
                oLCD_START <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lcd_status_display.md
# lcd_status_display

Parametrised HD44780 text driver for the elevator status panel. It runs the LCD power-up command sequence once. It then renders a two-line frame: the motion state on line 1 and the current floor in decimal on line 2. It rewrites the frame whenever the motion/floor inputs change. It sits between the elevator controller and the existing `LCD_Controller`, driving that block's start/done byte handshake.

## Interface
- `DLY_CYCLES`, 262142: idle cycles inserted after every completed byte; must be ≥1.
- `LINE_LEN`, 16: visible characters per line, range 8..40.
- `FLOOR_W`, 4: width of the floor input, range 1..9 (values up to 511).
- `iCLK`  in  1  system clock; all logic on rising edge.
- `iRST_N`  in  1  reset, synchronous, active-low.
- `iMOVE`  in  2  motion code: 0 stopped, 1 up, 2 down, 3 reserved.
- `iFLOOR`  in  FLOOR_W  current floor, unsigned binary.
- `oLCD_DATA`  out  8  byte to `LCD_Controller.iDATA`.
- `oLCD_RS`  out  1  0 = command, 1 = character.
- `oLCD_START`  out  1  byte request to `LCD_Controller.iStart`.
- `iLCD_DONE`  in  1  from `LCD_Controller.oDone`; byte accepted.
- `oBUSY`  out  1  high while the init sequence or a frame is being sent.

## Operation
- Init sequence (RS=0), once per reset: 0x38, 0x0C, 0x01, 0x06.
- Frame of 2·LINE_LEN+2 bytes:
  - 0x80 (RS=0).
  - LINE_LEN line-1 chars.
  - 0xC0 (RS=0).
  - LINE_LEN line-2 chars.
- Line 1 text by code: 0 "Parado", 1 "Subindo", 2 "Descendo", 3 "Erro". The rest of the line is spaces (0x20).
- Line 2 text:
  - "Andar" in columns 0..4, space in column 5.
  - Floor in columns 6..8 as three right-justified decimal digits. Leading zeros become spaces; the units digit is always shown.
  - Columns 9.. are spaces.
- Snapshot: `iMOVE`/`iFLOOR` are latched into shadow registers in the cycle a frame starts. All characters of that frame come from the snapshot only.
- Refresh rule:
  - After init, the first frame starts unconditionally.
  - After each frame, if the live inputs differ from the snapshot, a new frame starts immediately. Otherwise the block waits in IDLE.
  - An input change mid-frame never aborts the frame. It is caught by the post-frame compare.
- Binary-to-BCD conversion of the snapshot must finish before line-2 column 6 is issued. It may be combinational or multi-cycle.

## Timing
- Byte FSM states: IDLE, LOAD, WAIT, DELAY, NEXT.
  - LOAD (1 cycle): drive `oLCD_DATA`/`oLCD_RS` and set `oLCD_START`=1, then go to WAIT.
  - WAIT: hold all outputs until `iLCD_DONE`=1, then clear `oLCD_START` and go to DELAY.
  - DELAY: count exactly DLY_CYCLES cycles, then go to NEXT.
  - NEXT (1 cycle): advance the byte index. On the last byte of a sequence, go to IDLE/compare; otherwise go to LOAD.
- Per-byte cost: 1 + N_wait + 1 + DLY_CYCLES + 1 cycles.
- `oLCD_DATA`/`oLCD_RS` are stable from LOAD through the end of WAIT.
- `iLCD_DONE` is ignored in every state except WAIT.
- During reset (iRST_N=0 at a clock edge): `oLCD_DATA`=0, `oLCD_RS`=0, `oLCD_START`=0, `oBUSY`=0; FSM=IDLE; index=0; init-pending flag set.
- First cycle after reset release: go to LOAD with 0x38. `oBUSY`=1 from that edge.
- `oBUSY` drops on the NEXT→IDLE edge. When a refresh is due, `oBUSY` stays high with no gap between frames.
- Reset asserted mid-byte (even with `oLCD_START` high): all state returns to reset values and the full init sequence is re-run.

## Configuration
- `LCD_ARROW_EN`:
  - Defined: line-1 column LINE_LEN-1 shows a direction glyph: 0x5E '^' (up), 0x76 'v' (down), 0x2D '-' (stopped), 0x3F '?' (reserved).
  - Undefined: that column is a space, and no glyph logic is synthesised.

## Structure
- Shared package `lcd_pkg` holds:
  - Motion-code constants.
  - LCD command constants: FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, LINE1 0x80, LINE2 0xC0.
  - The ASCII space constant.
  - The FSM state enum.
- Sub-module `lcd_status_rom`: combinational character generator. Inputs are the snapshot, BCD digits and column/line; the output is an 8-bit char.
- The top module keeps the FSM, delay counter, byte index, snapshot and compare logic.

## Test plan
- Reset release, DLY_CYCLES=4, `iLCD_DONE` pulsed 2 cycles after each start, iMOVE=0, iFLOOR=0:
  - Bytes 0x38, 0x0C, 0x01, 0x06, 0x80, 'P','a','r','a','d','o', 10×0x20, 0xC0, "Andar", 0x20, 0x20, 0x20, '0', 7×0x20.
  - `oBUSY` then falls.
- Idle display, then iMOVE=2, iFLOOR=12: exactly one frame (34 bytes, no init) with "Descendo" and digits ' ','1','2'.
- Change iFLOOR 3→5 at byte 10 of a frame: the frame completes with '3', then a second frame with '5' follows with `oBUSY` never dropping.
- `iLCD_DONE` held low 100 cycles in WAIT: `oLCD_START` and data held constant; no index advance.
- Assert iRST_N low while `oLCD_START`=1: next edge all outputs 0; after release the sequence restarts at 0x38.
- iFLOOR=511 with FLOOR_W=9: digits '5','1','1'.
- With `LCD_ARROW_EN` and iMOVE=1: column 15 of line 1 = 0x5E.
